// File: rtl/switch_arbiter.sv
// switch_arbiter: central crossbar scheduler for the 4-port switch.
// Each output has its own round-robin pointer and busy counter. A decision
// made at one clock edge produces a one-cycle grant pulse in the next cycle.
// The granted port's FIFO word is captured two cycles later and presented
// with a one-cycle out_valid pulse.
// Ports:
//   clk, rst_n  - clock (rising edge) and asynchronous active-low reset
//   port_req    - bit i: port i requests an output
//   pkt_dst     - port i one-hot destination mask at [4i+3:4i]
//   fifo_data   - port i FIFO output word at [DATA_W*i +: DATA_W]
//   grant       - one-cycle grant pulse per port (pops that port's FIFO)
//   out_valid   - bit d: out_data word d is new this cycle
//   out_data    - output d word at [DATA_W*d +: DATA_W]
//   out_src     - source port index for output d at [2d+1:2d]
//   dst_err     - bit i: port i requested with a non-one-hot pkt_dst
module switch_arbiter #(
  parameter int DATA_W      = 16,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          port_req,
  input  logic [15:0]         pkt_dst,
  input  logic [4*DATA_W-1:0] fifo_data,
  output logic [3:0]          grant,
  output logic [3:0]          out_valid,
  output logic [4*DATA_W-1:0] out_data,
  output logic [7:0]          out_src,
  output logic [3:0]          dst_err
);

  localparam logic [3:0] HOLD_C = 4'(HOLD_CYCLES);

  // True when exactly one bit of the mask is set.
  function automatic logic is_one_hot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  logic [3:0]          grant_r;
  logic [3:0]          dst_err_r;
  logic [3:0]          out_valid_r;
  logic [4*DATA_W-1:0] out_data_r;
  logic [7:0]          out_src_r;
  logic [1:0]          ptr_r [4];
  logic [3:0]          busy_r [4];
  // Capture pipeline: stage 1 is aligned with the grant cycle, stage 2 with
  // the cycle in which the popped FIFO word is visible on fifo_data.
  logic [3:0]          cap1_valid_r;
  logic [7:0]          cap1_src_r;
  logic [3:0]          cap2_valid_r;
  logic [7:0]          cap2_src_r;

  logic [3:0]          elig_s;
  logic [3:0]          err_s;
  logic [3:0]          cand_s [4];
  logic [3:0]          win_valid_s;
  logic [1:0]          win_idx_s [4];
  logic [3:0]          grant_s;

  // Port eligibility and invalid-destination detection.
  always_comb begin
    elig_s = 4'd0;
    err_s  = 4'd0;
    for (int i = 0; i < 4; i++) begin
      if (is_one_hot(pkt_dst[4*i +: 4])) begin
        // A port already holding its grant pulse must not be picked again.
        elig_s[i] = port_req[i] & ~grant_r[i];
        err_s[i]  = 1'b0;
      end else begin
        elig_s[i] = 1'b0;
        err_s[i]  = port_req[i];
      end
    end
  end

  // Per-output candidate masks; a busy output has no candidates.
  always_comb begin
    for (int d = 0; d < 4; d++) begin
      cand_s[d] = 4'd0;
      for (int i = 0; i < 4; i++) begin
        cand_s[d][i] = elig_s[i] & pkt_dst[4*i + d] & (busy_r[d] == 4'd0);
      end
    end
  end

  // Round-robin scan from each output's pointer; merge winners into grants.
  always_comb begin
    win_valid_s = 4'd0;
    grant_s     = 4'd0;
    for (int d = 0; d < 4; d++) begin
      win_idx_s[d] = 2'd0;
      for (int k = 0; k < 4; k++) begin
        logic [1:0] idx;
        idx = ptr_r[d] + 2'(k);
        if (!win_valid_s[d] && cand_s[d][idx]) begin
          win_valid_s[d] = 1'b1;
          win_idx_s[d]   = idx;
        end else begin
          win_valid_s[d] = win_valid_s[d];
        end
      end
      if (win_valid_s[d]) begin
        grant_s = grant_s | (4'd1 << win_idx_s[d]);
      end else begin
        grant_s = grant_s;
      end
    end
  end

  // Grant/error pulses, pointers, busy counters and the capture pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_r      <= 4'd0;
      dst_err_r    <= 4'd0;
      out_valid_r  <= 4'd0;
      out_data_r   <= '0;
      out_src_r    <= 8'd0;
      cap1_valid_r <= 4'd0;
      cap1_src_r   <= 8'd0;
      cap2_valid_r <= 4'd0;
      cap2_src_r   <= 8'd0;
      for (int d = 0; d < 4; d++) begin
        ptr_r[d]  <= 2'd0;
        busy_r[d] <= 4'd0;
      end
    end else begin
      grant_r      <= grant_s;
      dst_err_r    <= err_s;
      cap1_valid_r <= win_valid_s;
      cap2_valid_r <= cap1_valid_r;
      cap2_src_r   <= cap1_src_r;
      out_valid_r  <= cap2_valid_r;
      for (int d = 0; d < 4; d++) begin
        if (win_valid_s[d]) begin
          ptr_r[d]            <= win_idx_s[d] + 2'd1;
          busy_r[d]           <= HOLD_C;
          cap1_src_r[2*d +: 2] <= win_idx_s[d];
        end else if (busy_r[d] != 4'd0) begin
          busy_r[d] <= busy_r[d] - 4'd1;
        end
        // fifo_data now shows the word popped at the end of the grant cycle.
        if (cap2_valid_r[d]) begin
          out_data_r[DATA_W*d +: DATA_W] <= fifo_data[DATA_W*cap2_src_r[2*d +: 2] +: DATA_W];
          out_src_r[2*d +: 2]           <= cap2_src_r[2*d +: 2];
        end
      end
    end
  end

  assign grant     = grant_r;
  assign dst_err   = dst_err_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_src   = out_src_r;

endmodule

// File: tb/tb_switch_arbiter.sv
// Directed bench for switch_arbiter: stimulus pushes expected output words
// into per-output queues, a monitor pops and compares on every out_valid.
module tb_switch_arbiter;

  localparam int DATA_W = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  port_req;
  logic [15:0] pkt_dst;
  logic [63:0] fifo_data;
  logic [3:0]  grant;
  logic [3:0]  out_valid;
  logic [63:0] out_data;
  logic [7:0]  out_src;
  logic [3:0]  dst_err;

  int checks   = 0;
  int failures = 0;

  logic [17:0] exp_q [4][$];
  logic [17:0] mon_e;

  switch_arbiter #(.DATA_W(DATA_W), .HOLD_CYCLES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .port_req  (port_req),
    .pkt_dst   (pkt_dst),
    .fifo_data (fifo_data),
    .grant     (grant),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .dst_err   (dst_err)
  );

  always #5 clk = ~clk;

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One cycle; a port that sees its grant leaves ARB_WAIT (drops req).
  task automatic cyc();
    @(negedge clk);
    port_req = port_req & ~grant;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic set_port(input int p, input logic [3:0] dst, input logic [15:0] data);
    pkt_dst[4*p +: 4]    = dst;
    fifo_data[16*p +: 16] = data;
    port_req[p]          = 1'b1;
  endtask

  task automatic expect_out(input int d, input logic [1:0] src, input logic [15:0] data);
    exp_q[d].push_back({src, data});
  endtask

  // Monitor: every out_valid bit must match the next queued word.
  always @(negedge clk) begin
    for (int d = 0; d < 4; d++) begin
      if (out_valid[d]) begin
        checks++;
        if (exp_q[d].size() == 0) begin
          failures++;
          $display("FAIL out_unexpected d=%0d actual out_valid=1 required=0", d);
        end else begin
          mon_e = exp_q[d].pop_front();
          if ({out_src[2*d +: 2], out_data[16*d +: 16]} !== mon_e) begin
            failures++;
            $display("FAIL out_word d=%0d actual src=%0d data=%h required src=%0d data=%h",
                     d, out_src[2*d +: 2], out_data[16*d +: 16], mon_e[17:16], mon_e[15:0]);
          end
        end
      end
    end
  end

  initial begin
    logic [3:0] g_exp [7];
    rst_n     = 1'b0;
    port_req  = 4'd0;
    pkt_dst   = 16'd0;
    fifo_data = 64'd0;
    repeat (3) @(negedge clk);
    chk4("rst_grant", grant, 4'b0000);
    chk4("rst_out_valid", out_valid, 4'b0000);
    chk4("rst_dst_err", dst_err, 4'b0000);
    chk64("rst_out_data", out_data, 64'd0);
    chk64("rst_out_src", {56'd0, out_src}, 64'd0);
    rst_n = 1'b1;
    idle(2);

    // Single transfer: port 1 -> output 2.
    set_port(1, 4'b0100, 16'hA521);
    expect_out(2, 2'd1, 16'hA521);
    cyc(); chk4("t1_grant", grant, 4'b0010);
    cyc(); chk4("t1_grant_pulse", grant, 4'b0000);
    cyc(); chk4("t1_out_valid", out_valid, 4'b0100);
    cyc(); chk4("t1_out_valid_pulse", out_valid, 4'b0000);
    idle(4);

    // Contention: ports 0, 2, 3 all target output 0.
    set_port(0, 4'b0001, 16'h1000);
    set_port(2, 4'b0001, 16'h1002);
    set_port(3, 4'b0001, 16'h1003);
    expect_out(0, 2'd0, 16'h1000);
    expect_out(0, 2'd2, 16'h1002);
    expect_out(0, 2'd3, 16'h1003);
    g_exp = '{4'b0001, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b1000};
    for (int k = 0; k < 7; k++) begin
      cyc();
      chk4($sformatf("t2_grant_c%0d", k + 1), grant, g_exp[k]);
    end
    idle(5);

    // Parallel outputs: port 0 -> output 1, port 3 -> output 3.
    set_port(0, 4'b0010, 16'h2000);
    set_port(3, 4'b1000, 16'h2333);
    expect_out(1, 2'd0, 16'h2000);
    expect_out(3, 2'd3, 16'h2333);
    cyc(); chk4("t3_grant", grant, 4'b1001);
    cyc();
    cyc(); chk4("t3_out_valid", out_valid, 4'b1010);
    idle(4);

    // Fairness wrap on output 1: grant port 2 to move ptr[1] to 3.
    set_port(2, 4'b0010, 16'h3002);
    expect_out(1, 2'd2, 16'h3002);
    cyc(); chk4("t4_grant_p2", grant, 4'b0100);
    idle(5);
    set_port(0, 4'b0010, 16'h3000);
    set_port(3, 4'b0010, 16'h3003);
    expect_out(1, 2'd3, 16'h3003);
    expect_out(1, 2'd0, 16'h3000);
    cyc(); chk4("t4_grant_wrap_p3", grant, 4'b1000);
    cyc(); cyc();
    cyc(); chk4("t4_grant_wrap_p0", grant, 4'b0001);
    idle(4);
    // ptr[1] should now be 1: between ports 0 and 2, port 2 wins.
    set_port(0, 4'b0010, 16'h3100);
    set_port(2, 4'b0010, 16'h3102);
    expect_out(1, 2'd2, 16'h3102);
    expect_out(1, 2'd0, 16'h3100);
    cyc(); chk4("t4_ptr1_p2", grant, 4'b0100);
    cyc(); cyc();
    cyc(); chk4("t4_ptr1_p0", grant, 4'b0001);
    idle(4);

    // Bad destination: non-one-hot mask for three cycles.
    set_port(2, 4'b0110, 16'h4444);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk4($sformatf("t5_dst_err_c%0d", k + 1), dst_err, 4'b0100);
      chk4($sformatf("t5_grant_c%0d", k + 1), grant, 4'b0000);
    end
    port_req[2] = 1'b0;
    cyc(); chk4("t5_dst_err_end", dst_err, 4'b0000);
    idle(4);

    // Reset in G+1: the in-flight word must be dropped.
    set_port(1, 4'b0001, 16'h5111);
    cyc(); chk4("t6_grant", grant, 4'b0010);
    cyc();
    rst_n    = 1'b0;
    port_req = 4'd0;
    #1;
    chk4("t6_rst_grant", grant, 4'b0000);
    chk4("t6_rst_out_valid", out_valid, 4'b0000);
    chk64("t6_rst_out_data", out_data, 64'd0);
    chk64("t6_rst_out_src", {56'd0, out_src}, 64'd0);
    idle(2);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk4($sformatf("t6_no_valid_c%0d", k + 1), out_valid, 4'b0000);
    end
    // ptr[0] back at 0: between ports 1 and 3, port 1 wins immediately.
    set_port(1, 4'b0001, 16'h6111);
    set_port(3, 4'b0001, 16'h6333);
    expect_out(0, 2'd1, 16'h6111);
    expect_out(0, 2'd3, 16'h6333);
    cyc(); chk4("t6_post_grant_p1", grant, 4'b0010);
    cyc(); cyc();
    cyc(); chk4("t6_post_grant_p3", grant, 4'b1000);
    idle(6);

    for (int d = 0; d < 4; d++) begin
      chk64($sformatf("queue_empty_d%0d", d), 64'(exp_q[d].size()), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
